// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit memory initiator:
//   - default address / data widths
//   - FSM state encoding (IDLE, REQ, WAIT_R)
// No ports.
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam int unsigned LSU_ADDR_W = 8;
    localparam int unsigned LSU_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/lsu_mem_initiator_if.sv
// -----------------------------------------------------------------------------
// lsu_mem_initiator_if
// Data-memory request bus (req/gnt/rvalid handshake).
//   mem_req    initiator -> memory  request valid
//   mem_we     initiator -> memory  1 = write, 0 = read
//   mem_addr   initiator -> memory  request address
//   mem_wdata  initiator -> memory  write data
//   mem_gnt    memory -> initiator  request accepted this cycle
//   mem_rvalid memory -> initiator  read data valid
//   mem_rdata  memory -> initiator  read data
// Modports: master (load/store unit), slave (memory).
// -----------------------------------------------------------------------------
interface lsu_mem_initiator_if #(
    parameter int unsigned ADDR_W = lsu_pkg::LSU_ADDR_W,
    parameter int unsigned DATA_W = lsu_pkg::LSU_DATA_W
);

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/lsu_timeout_ctr.sv
// -----------------------------------------------------------------------------
// lsu_timeout_ctr
// Outstanding-access watchdog. Counts cycles while enabled, saturating at
// TIMEOUT; o_expired is high while the count equals TIMEOUT.
//   clk        clock
//   reset      asynchronous active-low reset
//   i_clear    restart count at 0 (priority over enable)
//   i_enable   count this cycle
//   o_expired  count == TIMEOUT
// -----------------------------------------------------------------------------
module lsu_timeout_ctr #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    assign o_expired = (r_cnt == CW'(TIMEOUT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !o_expired) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// -----------------------------------------------------------------------------
// lsu_mem_initiator
// Load/store unit initiator for the data memory. Accepts one op at a time from
// the EX/MEM boundary, issues it on a req/gnt/rvalid bus and returns load
// data; stalls the pipeline (busy) while an access is outstanding.
//   clk, reset          clock, asynchronous active-low reset
//   op_valid/read/write pipeline op strobe and type (write wins if both)
//   op_addr, op_wdata   effective address, store data
//   op_ready, busy      unit idle / access outstanding
//   load_valid          1-cycle pulse, load_data updated
//   load_data           most recent load result
//   store_done          1-cycle pulse, store granted
//   err                 1-cycle pulse, access aborted by timeout
//   mem_bus             memory request bus (master side)
// Optional feature macro: LSU_TIMEOUT_EN (abort after TIMEOUT cycles).
// -----------------------------------------------------------------------------
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W  = LSU_ADDR_W,
    parameter int unsigned DATA_W  = LSU_DATA_W,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    input  logic              op_read,
    input  logic              op_write,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [DATA_W-1:0] op_wdata,
    output logic              op_ready,
    output logic              busy,
    output logic              load_valid,
    output logic [DATA_W-1:0] load_data,
    output logic              store_done,
    output logic              err,
    lsu_mem_initiator_if.master mem_bus
);

    lsu_state_e        r_state;
    lsu_state_e        w_next;
    logic              w_accept;
    logic              w_st_done;
    logic              w_ld_done;
    logic              w_expired;

    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_load_data;
    logic              r_load_valid;
    logic              r_store_done;

    assign op_ready          = (r_state == IDLE);
    assign busy              = (r_state != IDLE);
    assign mem_bus.mem_req   = (r_state == REQ);
    assign mem_bus.mem_we    = r_we;
    assign mem_bus.mem_addr  = r_addr;
    assign mem_bus.mem_wdata = r_wdata;
    assign load_valid        = r_load_valid;
    assign load_data         = r_load_data;
    assign store_done        = r_store_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Completion is checked before expiry so a response arriving in the
    // expiry cycle still succeeds.
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_st_done = 1'b0;
        w_ld_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (op_valid && (op_read || op_write)) begin
                    w_accept = 1'b1;
                    w_next   = REQ;
                end
            end
            REQ: begin
                if (mem_bus.mem_gnt) begin
                    if (r_we) begin
                        w_st_done = 1'b1;
                        w_next    = IDLE;
                    end else if (mem_bus.mem_rvalid) begin
                        w_ld_done = 1'b1;
                        w_next    = IDLE;
                    end else begin
                        w_next = WAIT_R;
                    end
                end else if (w_expired) begin
                    w_next = IDLE;
                end
            end
            WAIT_R: begin
                if (mem_bus.mem_rvalid) begin
                    w_ld_done = 1'b1;
                    w_next    = IDLE;
                end else if (w_expired) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_load_data  <= '0;
            r_load_valid <= 1'b0;
            r_store_done <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= op_write;
                r_addr  <= op_addr;
                r_wdata <= op_wdata;
            end
            if (w_ld_done) begin
                r_load_data <= mem_bus.mem_rdata;
            end
            r_load_valid <= w_ld_done;
            r_store_done <= w_st_done;
        end
    end

`ifdef LSU_TIMEOUT_EN
    logic w_abort;
    logic r_err;

    lsu_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_accept),
        .i_enable  (busy),
        .o_expired (w_expired)
    );

    assign w_abort = w_expired && busy && !(w_st_done || w_ld_done);
    assign err     = r_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_abort;
        end
    end
`else
    assign w_expired = 1'b0;
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_initiator
// Self-checking bench for lsu_mem_initiator: table of ops applied in a loop
// against a bench-side memory responder with programmable gnt/rvalid delays,
// a result scoreboard, plus hand-written reset / long-wait / timeout sequences.
// -----------------------------------------------------------------------------
module tb_lsu_mem_initiator;

    localparam int unsigned KIND_NONE  = 0;
    localparam int unsigned KIND_STORE = 1;
    localparam int unsigned KIND_LOAD  = 2;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        int          gd;
        int          rdly;
        int unsigned kind;
        logic [7:0]  exp_data;
    } vec_t;

    typedef struct {
        int unsigned kind;
        logic [7:0]  data;
    } sb_t;

    logic       clk;
    logic       reset;
    logic       op_valid;
    logic       op_read;
    logic       op_write;
    logic [7:0] op_addr;
    logic [7:0] op_wdata;
    logic       op_ready;
    logic       busy;
    logic       load_valid;
    logic [7:0] load_data;
    logic       store_done;
    logic       err;

    int checks;
    int errors;
    sb_t sb_q[$];
    vec_t vecs[12];

    // memory responder controls / state
    logic       resp_en;
    int         gnt_delay;
    int         rv_delay;
    logic       r_gnt, r_rv;
    logic [7:0] r_rdata;
    logic       man_gnt, man_rv;
    logic [7:0] man_rdata;
    logic [7:0] sim_mem [256];
    int         phase, gcnt, rcnt;
    logic [7:0] raddr;

    lsu_mem_initiator_if #(.ADDR_W(8), .DATA_W(8)) mem_if ();

    assign mem_if.mem_gnt    = resp_en ? r_gnt   : man_gnt;
    assign mem_if.mem_rvalid = resp_en ? r_rv    : man_rv;
    assign mem_if.mem_rdata  = resp_en ? r_rdata : man_rdata;

    lsu_mem_initiator #(
        .ADDR_W  (8),
        .DATA_W  (8),
        .TIMEOUT (15)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .op_valid   (op_valid),
        .op_read    (op_read),
        .op_write   (op_write),
        .op_addr    (op_addr),
        .op_wdata   (op_wdata),
        .op_ready   (op_ready),
        .busy       (busy),
        .load_valid (load_valid),
        .load_data  (load_data),
        .store_done (store_done),
        .err        (err),
        .mem_bus    (mem_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: grants gnt_delay cycles after mem_req first appears,
    // returns read data rv_delay cycles after the grant (same cycle if 0).
    always @(negedge clk) begin
        r_gnt = 1'b0;
        r_rv  = 1'b0;
        if (!resp_en || !reset) begin
            phase = 0;
            gcnt  = 0;
        end else if (phase == 0) begin
            if (mem_if.mem_req) begin
                if (gcnt == gnt_delay) begin
                    r_gnt = 1'b1;
                    gcnt  = 0;
                    if (mem_if.mem_we) begin
                        sim_mem[mem_if.mem_addr] = mem_if.mem_wdata;
                    end else if (rv_delay == 0) begin
                        r_rv    = 1'b1;
                        r_rdata = sim_mem[mem_if.mem_addr];
                    end else begin
                        phase = 1;
                        rcnt  = 0;
                        raddr = mem_if.mem_addr;
                    end
                end else begin
                    gcnt = gcnt + 1;
                end
            end else begin
                gcnt = 0;
            end
        end else begin
            rcnt = rcnt + 1;
            if (rcnt == rv_delay) begin
                r_rv    = 1'b1;
                r_rdata = sim_mem[raddr];
                phase   = 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Any completion pulse must match the oldest outstanding expectation.
    task automatic sb_check();
        sb_t e;
        int unsigned got;
        if (load_valid || store_done) begin
            checks++;
            got = store_done ? KIND_STORE : KIND_LOAD;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_empty: got kind %0d with nothing expected", got);
            end else begin
                e = sb_q.pop_front();
                if (got != e.kind || (e.kind == KIND_LOAD && load_data !== e.data)) begin
                    errors++;
                    $display("FAIL sb_result: got kind %0d data %0h expected kind %0d data %0h",
                             got, load_data, e.kind, e.data);
                end
            end
        end
    endtask

    task automatic drive_op(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
        op_valid = 1'b1;
        op_read  = rd;
        op_write = wr;
        op_addr  = a;
        op_wdata = d;
    endtask

    task automatic clear_op();
        op_valid = 1'b0;
        op_read  = 1'b0;
        op_write = 1'b0;
        op_addr  = '0;
        op_wdata = '0;
    endtask

    // Applies one op; returns at the cycle its pulse is visible so the next
    // op is issued back-to-back.
    task automatic run_op(input vec_t v);
        int L;
        sb_t e;
        gnt_delay = v.gd;
        rv_delay  = v.rdly;
        chk("ready_before_op", op_ready, 1'b1);
        drive_op(v.rd, v.wr, v.addr, v.wdata);
        if (v.kind != KIND_NONE) begin
            e.kind = v.kind;
            e.data = v.exp_data;
            sb_q.push_back(e);
        end
        if (v.kind == KIND_NONE) begin
            tick();
            clear_op();
            for (int k = 1; k <= 3; k++) begin
                if (k > 1) tick();
                chk("nop_busy", busy, 1'b0);
                chk("nop_req", mem_if.mem_req, 1'b0);
                chk("nop_pulse", {load_valid, store_done, err}, 3'b000);
            end
            return;
        end
        L = (v.kind == KIND_STORE) ? 2 + v.gd : 2 + v.gd + v.rdly;
        for (int k = 1; k <= L; k++) begin
            tick();
            if (k == 1) clear_op();
            chk("busy", busy, (k < L));
            chk("mem_req", mem_if.mem_req, (k <= 1 + v.gd));
            if (k <= 1 + v.gd) begin
                chk("mem_addr", mem_if.mem_addr, v.addr);
                chk("mem_we", mem_if.mem_we, v.wr);
                if (v.wr) chk("mem_wdata", mem_if.mem_wdata, v.wdata);
            end
            chk("load_valid", load_valid, (k == L && v.kind == KIND_LOAD));
            chk("store_done", store_done, (k == L && v.kind == KIND_STORE));
            chk("err", err, 1'b0);
            sb_check();
        end
        chk("ready_after_op", op_ready, 1'b1);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        resp_en   = 1'b1;
        gnt_delay = 0;
        rv_delay  = 0;
        man_gnt   = 1'b0;
        man_rv    = 1'b0;
        man_rdata = '0;
        r_gnt     = 1'b0;
        r_rv      = 1'b0;
        r_rdata   = '0;
        for (int unsigned i = 0; i < 256; i++) sim_mem[i] = 8'(i) ^ 8'h5A;
        sim_mem[8'h20] = 8'h3C;

        //         rd    wr    addr   wdata  gd rd kind        exp
        vecs[0]  = '{1'b0, 1'b1, 8'h10, 8'hA5, 0, 0, KIND_STORE, 8'h00};
        vecs[1]  = '{1'b1, 1'b0, 8'h20, 8'h00, 0, 0, KIND_LOAD,  8'h3C};
        vecs[2]  = '{1'b1, 1'b0, 8'h10, 8'h00, 2, 3, KIND_LOAD,  8'hA5};
        vecs[3]  = '{1'b1, 1'b1, 8'h05, 8'h77, 0, 0, KIND_STORE, 8'h00};
        vecs[4]  = '{1'b1, 1'b0, 8'h05, 8'h00, 0, 0, KIND_LOAD,  8'h77};
        vecs[5]  = '{1'b0, 1'b0, 8'h33, 8'h44, 0, 0, KIND_NONE,  8'h00};
        vecs[6]  = '{1'b0, 1'b1, 8'hFF, 8'h00, 1, 0, KIND_STORE, 8'h00};
        vecs[7]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 0, 1, KIND_LOAD,  8'h00};
        vecs[8]  = '{1'b1, 1'b0, 8'h00, 8'h00, 3, 0, KIND_LOAD,  8'h5A};
        vecs[9]  = '{1'b0, 1'b1, 8'h80, 8'hC3, 0, 0, KIND_STORE, 8'h00};
        vecs[10] = '{1'b1, 1'b0, 8'h80, 8'h00, 1, 2, KIND_LOAD,  8'hC3};
        vecs[11] = '{1'b1, 1'b0, 8'h20, 8'h00, 0, 0, KIND_LOAD,  8'h3C};

        reset = 1'b0;
        clear_op();
        #1;
        chk("rst_op_ready", op_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_req", mem_if.mem_req, 1'b0);
        chk("rst_we", mem_if.mem_we, 1'b0);
        chk("rst_addr", mem_if.mem_addr, 8'h00);
        chk("rst_wdata", mem_if.mem_wdata, 8'h00);
        chk("rst_load_data", load_data, 8'h00);
        chk("rst_pulses", {load_valid, store_done, err}, 3'b000);
        tick();
        tick();
        reset = 1'b1;

        for (int i = 0; i < 11; i++) run_op(vecs[i]);
        tick();
        chk("pulse_width", {load_valid, store_done, err}, 3'b000);

        // reset while waiting for read data
        resp_en = 1'b0;
        drive_op(1'b1, 1'b0, 8'h20, 8'h00);
        tick();
        clear_op();
        chk("wr_req", mem_if.mem_req, 1'b1);
        man_gnt = 1'b1;
        tick();
        man_gnt = 1'b0;
        chk("wr_in_wait_busy", busy, 1'b1);
        chk("wr_in_wait_req", mem_if.mem_req, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("wr_rst_busy", busy, 1'b0);
        chk("wr_rst_ready", op_ready, 1'b1);
        chk("wr_rst_req", mem_if.mem_req, 1'b0);
        chk("wr_rst_addr", mem_if.mem_addr, 8'h00);
        chk("wr_rst_load_data", load_data, 8'h00);
        tick();
        reset     = 1'b1;
        man_rv    = 1'b1;
        man_rdata = 8'hEE;
        tick();
        man_rv = 1'b0;
        chk("stale_rvalid_lv", load_valid, 1'b0);
        chk("stale_rvalid_data", load_data, 8'h00);
        chk("stale_rvalid_busy", busy, 1'b0);
        resp_en = 1'b1;
        run_op(vecs[11]);

`ifdef LSU_TIMEOUT_EN
        // memory never grants: abort 16 cycles after entering REQ
        gnt_delay = 100000;
        drive_op(1'b1, 1'b0, 8'h20, 8'h00);
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 1) clear_op();
            chk("to_req", mem_if.mem_req, (k <= 16));
            chk("to_busy", busy, (k < 17));
            chk("to_err", err, (k == 17));
            chk("to_lv", load_valid, 1'b0);
        end
        chk("to_load_data", load_data, 8'h3C);
        tick();
        chk("to_err_width", err, 1'b0);
        run_op(vecs[9]);
`else
        // no timeout: a never-granted request stays outstanding
        resp_en = 1'b0;
        drive_op(1'b0, 1'b1, 8'h44, 8'h99);
        begin
            sb_t e;
            e.kind = KIND_STORE;
            e.data = 8'h00;
            sb_q.push_back(e);
        end
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 1) clear_op();
            chk("long_req", mem_if.mem_req, 1'b1);
            chk("long_addr", mem_if.mem_addr, 8'h44);
            chk("long_err", err, 1'b0);
            chk("long_sd", store_done, 1'b0);
        end
        man_gnt = 1'b1;
        tick();
        man_gnt = 1'b0;
        chk("long_sd_pulse", store_done, 1'b1);
        chk("long_busy", busy, 1'b0);
        sb_check();
        tick();
        chk("long_sd_width", store_done, 1'b0);
        resp_en = 1'b1;
`endif

        tick();
        chk("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
